// File: rtl/psum_scratch_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : psum_scratch_drain_if
// Description : Control, scratchpad-read and output-stream bundle for the
//               psum scratch drain. clr_* write-back signals exist only when
//               PSUM_DRAIN_CLR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface psum_scratch_drain_if #(
    parameter int ADDR_LEN      = 4,
    parameter int SCRATCH_WIDTH = 16
);
    // drain control
    logic                     start;
    logic [ADDR_LEN-1:0]      base_addr;
    logic [ADDR_LEN:0]        count;
    logic                     busy;
    logic                     done;
    // scratchpad read port
    logic [ADDR_LEN-1:0]      raddr;
    logic [SCRATCH_WIDTH-1:0] rdata;
    // downstream stream
    logic                     out_valid;
    logic                     out_ready;
    logic [SCRATCH_WIDTH-1:0] out_data;
    logic                     out_last;
`ifdef PSUM_DRAIN_CLR_EN
    // scratchpad write-back (zero after drain)
    logic                     clr_wen;
    logic [ADDR_LEN-1:0]      clr_waddr;
    logic [SCRATCH_WIDTH-1:0] clr_din;
`endif

    modport master (
`ifdef PSUM_DRAIN_CLR_EN
        output clr_wen, clr_waddr, clr_din,
`endif
        input  start, base_addr, count, rdata, out_ready,
        output busy, done, raddr, out_valid, out_data, out_last
    );

    modport slave (
`ifdef PSUM_DRAIN_CLR_EN
        input  clr_wen, clr_waddr, clr_din,
`endif
        output start, base_addr, count, rdata, out_ready,
        input  busy, done, raddr, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/psum_scratch_drain.sv
`default_nettype none
// ============================================================================
// Module      : psum_scratch_drain
// Description : Streams a wrap-around window of the psum scratchpad out on a
//               valid/ready port. Define PSUM_DRAIN_CLR_EN to zero each word
//               in the scratchpad as it is drained.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_scratch_drain #(
    parameter int ADDR_LEN      = 4,
    parameter int SCRATCH_DEPTH = 16,
    parameter int SCRATCH_WIDTH = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    psum_scratch_drain_if.master bus
);

    localparam logic [ADDR_LEN:0]   c_depth     = (ADDR_LEN+1)'(SCRATCH_DEPTH);
    localparam logic [ADDR_LEN:0]   c_cnt_one   = (ADDR_LEN+1)'(1);
    localparam logic [ADDR_LEN-1:0] c_ptr_one   = ADDR_LEN'(1);
    localparam logic [ADDR_LEN-1:0] c_last_addr = ADDR_LEN'(SCRATCH_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [ADDR_LEN-1:0]      r_ptr;
    logic [ADDR_LEN:0]        r_remaining;
    logic                     r_out_valid;
    logic [SCRATCH_WIDTH-1:0] r_out_data;
    logic                     r_out_last;

    logic [ADDR_LEN:0]        w_count_clamped;
    logic [ADDR_LEN-1:0]      w_ptr_next;
    logic                     w_load;
    logic                     w_accept;
    logic                     w_last_hs;
    logic                     w_launch;

    assign w_count_clamped = (bus.count > c_depth) ? c_depth : bus.count;
    assign w_ptr_next      = (r_ptr == c_last_addr) ? '0 : r_ptr + c_ptr_one;

    // Load whenever the output register is empty or being emptied this edge,
    // so a held-high out_ready yields one word per cycle.
    assign w_load    = (r_state == ST_STREAM) && (r_remaining != '0) &&
                       (!r_out_valid || bus.out_ready);
    assign w_accept  = r_out_valid && bus.out_ready;
    assign w_last_hs = w_accept && r_out_last;
    assign w_launch  = (r_state == ST_IDLE) && bus.start && (w_count_clamped != '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = (w_count_clamped == '0) ? ST_FINISH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_last_hs) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Window pointer and remaining-word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_remaining <= '0;
        end else if (w_launch) begin
            r_ptr       <= bus.base_addr;
            r_remaining <= w_count_clamped;
        end else if (w_load) begin
            r_ptr       <= w_ptr_next;
            r_remaining <= r_remaining - c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Output register: loaded from the combinational scratch read, held
    // stable while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.rdata;
            r_out_last  <= (r_remaining == c_cnt_one);
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign bus.raddr     = r_ptr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_FINISH);

`ifdef PSUM_DRAIN_CLR_EN
    // Zero the word in the same cycle it is read; the scratch write lands on
    // the same edge that captures the old value into out_data.
    assign bus.clr_wen   = w_load;
    assign bus.clr_waddr = r_ptr;
    assign bus.clr_din   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_psum_scratch_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_scratch_drain
// Description : Scoreboard bench for psum_scratch_drain with a scratchpad
//               model and random back-pressure (PSUM_DRAIN_CLR_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_scratch_drain;

    localparam int ADDR_LEN = 4;
    localparam int DEPTH    = 16;
    localparam int W        = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psum_scratch_drain_if #(.ADDR_LEN(ADDR_LEN), .SCRATCH_WIDTH(W)) bus();

    psum_scratch_drain #(
        .ADDR_LEN      (ADDR_LEN),
        .SCRATCH_DEPTH (DEPTH),
        .SCRATCH_WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // scratchpad model and reference contents
    logic [W-1:0] mem     [DEPTH];
    logic [W-1:0] ref_mem [DEPTH];
    logic         load_req = 1'b0;

    assign bus.rdata = mem[bus.raddr];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
        end
`ifdef PSUM_DRAIN_CLR_EN
        else if (bus.clr_wen) begin
            mem[bus.clr_waddr] <= bus.clr_din;
        end
`endif
    end

    exp_t                sb_q  [$];
    logic [ADDR_LEN-1:0] clr_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;
    int ready_mode = 0;
    logic manual_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: window of min(count,DEPTH) words from base, modulo DEPTH.
    task automatic push_window(input int base, input int cnt);
        int   n;
        int   a;
        exp_t e;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        for (int i = 0; i < n; i++) begin
            a      = (base + i) % DEPTH;
            e.data = ref_mem[a];
            e.last = (i == n - 1);
            sb_q.push_back(e);
`ifdef PSUM_DRAIN_CLR_EN
            clr_q.push_back(ADDR_LEN'(a));
            ref_mem[a] = '0;
`endif
        end
    endtask

    task automatic preload(input bit incr);
        for (int i = 0; i < DEPTH; i++)
            ref_mem[i] = incr ? W'(i + 100) : W'($urandom);
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic pulse_start(input int base, input int cnt);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = ADDR_LEN'(base);
        bus.count     = (ADDR_LEN+1)'(cnt);
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int c;
        c = 0;
        while (done_cnt == d0 && c < 400) begin
            @(posedge clk);
            c++;
        end
        check("done_seen", 32'(done_cnt != d0), 1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 0);
        check("busy_after_done", 32'(bus.busy), 0);
        repeat (3) @(posedge clk);
        check("done_pulses", 32'(done_cnt - d0), 1);
        check("sb_drained", 32'(sb_q.size()), 0);
`ifdef PSUM_DRAIN_CLR_EN
        check("clr_drained", 32'(clr_q.size()), 0);
`endif
    endtask

    task automatic run_drain(input int base, input int cnt, input bit extra);
        int d0;
        d0 = done_cnt;
        push_window(base, cnt);
        pulse_start(base, cnt);
        if (extra) pulse_start($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH));
        wait_done(d0);
    endtask

    // back-pressure driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = manual_ready;
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_data;
        logic         prev_last;
        exp_t         e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.out_valid), 1);
                    check("stall_data", 32'(bus.out_data), 32'(prev_data));
                    check("stall_last", 32'(bus.out_last), 32'(prev_last));
                end
                if (bus.done) done_cnt++;
                if (bus.out_valid && bus.out_ready) begin
                    hs_cnt++;
                    check("word_expected", 32'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("out_data", 32'(bus.out_data), 32'(e.data));
                        check("out_last", 32'(bus.out_last), 32'(e.last));
                    end
                end
`ifdef PSUM_DRAIN_CLR_EN
                if (bus.clr_wen) begin
                    check("clr_expected", 32'(clr_q.size() != 0), 1);
                    if (clr_q.size() != 0) begin
                        check("clr_waddr", 32'(bus.clr_waddr), 32'(clr_q.pop_front()));
                        check("clr_din", 32'(bus.clr_din), 0);
                    end
                end
`endif
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
            end
        end
    end

    // stimulus
    initial begin
        int d0;
        int h0;
        int c;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.count     = '0;
        preload(1'b1);
        #1;
        check("rst_raddr", 32'(bus.raddr), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_data", 32'(bus.out_data), 0);
        check("rst_last", 32'(bus.out_last), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
`ifdef PSUM_DRAIN_CLR_EN
        check("rst_clr_wen", 32'(bus.clr_wen), 0);
        check("rst_clr_waddr", 32'(bus.clr_waddr), 0);
        check("rst_clr_din", 32'(bus.clr_din), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // base 2, count 4 at full throughput: latency and back-to-back words
        ready_mode = 0;
        d0 = done_cnt;
        push_window(2, 4);
        pulse_start(2, 4);
        @(negedge clk);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_first_gap", 32'(bus.out_valid), 0);
        check("t1_raddr", 32'(bus.raddr), 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_stream_valid", 32'(bus.out_valid), 1);
        end
        @(negedge clk);
        check("t1_valid_drop", 32'(bus.out_valid), 0);
        check("t1_done", 32'(bus.done), 1);
        wait_done(d0);

        // wrap-around window
        preload(1'b1);
        run_drain(14, 5, 1'b0);

        // ready low for 3 cycles after the first word
        preload(1'b1);
        ready_mode   = 2;
        manual_ready = 1'b0;
        @(posedge clk); #1;
        d0 = done_cnt;
        h0 = hs_cnt;
        push_window(2, 4);
        pulse_start(2, 4);
        c = 0;
        while (!bus.out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("t3_first_valid", 32'(bus.out_valid), 1);
        repeat (3) @(negedge clk);
        manual_ready = 1'b1;
        wait_done(d0);
        check("t3_handshakes", 32'(hs_cnt - h0), 4);
        ready_mode = 0;

        // count = 0
        d0 = done_cnt;
        pulse_start(5, 0);
        @(negedge clk);
        check("t4_done", 32'(bus.done), 1);
        check("t4_no_valid", 32'(bus.out_valid), 0);
        wait_done(d0);

        // start while busy is ignored
        preload(1'b0);
        run_drain(7, 6, 1'b1);

        // count above depth is clamped
        preload(1'b0);
        run_drain(3, 20, 1'b0);

        // reset after 2 of 6 words
        preload(1'b1);
        d0 = done_cnt;
        h0 = hs_cnt;
        push_window(0, 6);
        pulse_start(0, 6);
        c = 0;
        while (hs_cnt - h0 < 2 && c < 50) begin
            @(posedge clk);
            c++;
        end
        check("t5_two_words", 32'(hs_cnt - h0), 2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 0);
        check("t5_rst_data", 32'(bus.out_data), 0);
        check("t5_rst_last", 32'(bus.out_last), 0);
        check("t5_rst_raddr", 32'(bus.raddr), 0);
        check("t5_rst_busy", 32'(bus.busy), 0);
        check("t5_rst_done", 32'(bus.done), 0);
        sb_q.delete();
        clr_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        check("t5_no_done", 32'(done_cnt - d0), 0);
        preload(1'b1);
        run_drain(0, 6, 1'b0);

`ifdef PSUM_DRAIN_CLR_EN
        // full clear then re-drain yields zeros
        preload(1'b1);
        run_drain(0, 16, 1'b0);
        run_drain(0, 16, 1'b0);
`endif

        // random windows under random back-pressure
        ready_mode = 1;
        for (int it = 0; it < 30; it++) begin
            int b;
            int n;
            preload(1'b0);
            b = $urandom_range(0, DEPTH - 1);
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH + 1, 31) : $urandom_range(0, DEPTH);
            run_drain(b, n, (n >= 2) && ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
